// File: rtl/bus_ready_controller_if.sv
// rtl/bus_ready_controller_if.sv - CPU/DMA bus command and ready signals for bus_ready_controller
interface bus_ready_controller_if;
  logic cpu_clock;
  logic address_enable_n;
  logic io_read_n;
  logic io_write_n;
  logic memory_read_n;
  logic memory_write_n;
  logic dma_wait_n;
  logic io_channel_ready;
  logic processor_ready;
  logic dma_ready;

  modport slave (
    input  cpu_clock,
    input  address_enable_n,
    input  io_read_n,
    input  io_write_n,
    input  memory_read_n,
    input  memory_write_n,
    input  dma_wait_n,
    input  io_channel_ready,
    output processor_ready,
    output dma_ready
  );

  modport master (
    output cpu_clock,
    output address_enable_n,
    output io_read_n,
    output io_write_n,
    output memory_read_n,
    output memory_write_n,
    output dma_wait_n,
    output io_channel_ready,
    input  processor_ready,
    input  dma_ready
  );
endinterface

// File: rtl/bus_ready_controller.sv
// rtl/bus_ready_controller.sv - wait-state generator driving processor_ready and dma_ready
// Optional macro BUS_READY_MEM_WAIT_EN: memory commands also insert MEM_WAIT_STATES wait states.
module bus_ready_controller #(
  parameter int IO_WAIT_STATES  = 1,
  parameter int MEM_WAIT_STATES = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  bus_ready_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    EXT_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [2:0] IO_COUNT = 3'(IO_WAIT_STATES);

  state_t     state;
  logic [2:0] counter;
  logic       cpu_clock_prev;
  logic       ready_meta;
  logic       ready_sync;
  logic       cpu_posedge;
  logic       cpu_negedge;
  logic       io_cmd;
  logic       mem_cmd;
  logic       cycle_request;
  logic       all_commands_idle;
  logic [2:0] load_count;

  assign cpu_posedge = ~cpu_clock_prev & bus.cpu_clock;
  assign cpu_negedge = cpu_clock_prev & ~bus.cpu_clock;

  assign io_cmd            = ~bus.io_read_n | ~bus.io_write_n;
  assign all_commands_idle = bus.io_read_n & bus.io_write_n &
                             bus.memory_read_n & bus.memory_write_n;

`ifdef BUS_READY_MEM_WAIT_EN
  localparam logic [2:0] MEM_COUNT = 3'(MEM_WAIT_STATES);
  assign mem_cmd = ~bus.memory_read_n | ~bus.memory_write_n;
`else
  // Memory cycles run at full speed; the memory wait count has no effect in this build.
  localparam logic [2:0] MEM_COUNT = 3'd0;
  localparam int unused_mem_wait_states = MEM_WAIT_STATES;
  assign mem_cmd = 1'b0;
`endif

  // I/O takes priority when an I/O and a memory command overlap.
  assign cycle_request = io_cmd | mem_cmd;
  assign load_count    = io_cmd ? IO_COUNT : MEM_COUNT;

  // dma_ready is loaded from the first synchroniser stage so it tracks ready_sync
  // cycle for cycle, giving the slot-ready path two clocks of latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_clock_prev <= 1'b0;
      ready_meta     <= 1'b1;
      ready_sync     <= 1'b1;
      bus.dma_ready  <= 1'b1;
    end else begin
      cpu_clock_prev <= bus.cpu_clock;
      ready_meta     <= bus.io_channel_ready;
      ready_sync     <= ready_meta;
      bus.dma_ready  <= bus.address_enable_n ? ready_meta : 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      counter             <= 3'd0;
      bus.processor_ready <= 1'b1;
    end else begin
      if (cpu_negedge) begin
        bus.processor_ready <= (state != WAIT) && (state != EXT_WAIT) && bus.dma_wait_n;
      end
      if (cpu_posedge) begin
        if (bus.address_enable_n) begin
          // DMA has taken the bus: abandon any CPU cycle in progress.
          state   <= IDLE;
          counter <= 3'd0;
        end else begin
          case (state)
            IDLE: begin
              if (cycle_request) begin
                if (load_count != 3'd0) begin
                  state   <= WAIT;
                  counter <= load_count;
                end else begin
                  state <= ready_sync ? DONE : EXT_WAIT;
                end
              end
            end
            WAIT: begin
              counter <= counter - 3'd1;
              if (counter == 3'd1) begin
                state <= ready_sync ? DONE : EXT_WAIT;
              end
            end
            EXT_WAIT: begin
              if (ready_sync) begin
                state <= DONE;
              end
            end
            DONE: begin
              if (all_commands_idle) begin
                state <= IDLE;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_ready_controller.sv
// tb/tb_bus_ready_controller.sv - directed self-checking bench for bus_ready_controller
module tb_bus_ready_controller;

`ifdef BUS_READY_MEM_WAIT_EN
  localparam int MEM_LOWS = 2;
`else
  localparam int MEM_LOWS = 0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  bus_ready_controller_if bus_a ();
  bus_ready_controller_if bus_b ();

  bus_ready_controller #(.IO_WAIT_STATES(1), .MEM_WAIT_STATES(2)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  bus_ready_controller #(.IO_WAIT_STATES(3), .MEM_WAIT_STATES(0)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One cpu_clock period: 4 clocks high, 4 low; samples processor_ready after the fall.
  task automatic cpu_period(output logic pr_a, output logic pr_b);
    bus_a.cpu_clock = 1'b1;
    bus_b.cpu_clock = 1'b1;
    repeat (4) @(negedge clock);
    bus_a.cpu_clock = 1'b0;
    bus_b.cpu_clock = 1'b0;
    repeat (4) @(negedge clock);
    pr_a = bus_a.processor_ready;
    pr_b = bus_b.processor_ready;
  endtask

  initial begin
    logic pa;
    logic pb;
    int   lows;

    bus_a.cpu_clock = 1'b0;        bus_b.cpu_clock = 1'b0;
    bus_a.address_enable_n = 1'b0; bus_b.address_enable_n = 1'b0;
    bus_a.io_read_n = 1'b1;        bus_b.io_read_n = 1'b1;
    bus_a.io_write_n = 1'b1;       bus_b.io_write_n = 1'b1;
    bus_a.memory_read_n = 1'b1;    bus_b.memory_read_n = 1'b1;
    bus_a.memory_write_n = 1'b1;   bus_b.memory_write_n = 1'b1;
    bus_a.dma_wait_n = 1'b1;       bus_b.dma_wait_n = 1'b1;
    bus_a.io_channel_ready = 1'b1; bus_b.io_channel_ready = 1'b1;

    repeat (3) @(negedge clock);
    check("reset_pr_a", bus_a.processor_ready, 1);
    check("reset_dma_a", bus_a.dma_ready, 1);
    check("reset_pr_b", bus_b.processor_ready, 1);
    check("reset_dma_b", bus_b.dma_ready, 1);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // One I/O wait state: low for the first period only.
    bus_a.io_read_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_period(pa, pb);
      check($sformatf("io1_period%0d", i), pa, (i == 0) ? 1'b0 : 1'b1);
    end
    bus_a.io_read_n = 1'b1;
    cpu_period(pa, pb);
    check("io1_release", pa, 1);
    bus_a.io_read_n = 1'b0;
    cpu_period(pa, pb);
    check("io1_restart_wait", pa, 0);
    cpu_period(pa, pb);
    check("io1_restart_done", pa, 1);
    bus_a.io_read_n = 1'b1;
    cpu_period(pa, pb);

    // Three wait states followed by five extended periods with the slot not ready.
    bus_b.io_write_n = 1'b0;
    bus_b.io_channel_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cpu_period(pa, pb);
      check($sformatf("ext_period%0d", i), pb, 0);
    end
    bus_b.io_channel_ready = 1'b1;
    repeat (3) @(negedge clock);
    cpu_period(pa, pb);
    check("ext_release", pb, 1);
    bus_b.io_write_n = 1'b1;
    cpu_period(pa, pb);
    check("ext_idle", pb, 1);

    // DMA owns the bus: dma_ready follows the slot ready two clocks later.
    bus_a.address_enable_n = 1'b1;
    repeat (2) @(negedge clock);
    check("dma_steady_high", bus_a.dma_ready, 1);
    bus_a.io_channel_ready = 1'b0;
    @(negedge clock);
    check("dma_fall_lat1", bus_a.dma_ready, 1);
    @(negedge clock);
    check("dma_fall_lat2", bus_a.dma_ready, 0);
    bus_a.io_channel_ready = 1'b1;
    @(negedge clock);
    check("dma_rise_lat1", bus_a.dma_ready, 0);
    @(negedge clock);
    check("dma_rise_lat2", bus_a.dma_ready, 1);
    bus_a.io_read_n = 1'b0;
    cpu_period(pa, pb);
    check("dma_owner_pr", pa, 1);
    check("cpu_owner_dma_ready", bus_b.dma_ready, 1);
    bus_a.io_read_n = 1'b1;
    bus_a.address_enable_n = 1'b0;
    cpu_period(pa, pb);
    check("dma_handback_pr", pa, 1);

    // dma_wait_n low while idle stalls the CPU for exactly those periods.
    bus_a.dma_wait_n = 1'b0;
    cpu_period(pa, pb);
    check("dma_wait_p1", pa, 0);
    cpu_period(pa, pb);
    check("dma_wait_p2", pa, 0);
    bus_a.dma_wait_n = 1'b1;
    cpu_period(pa, pb);
    check("dma_wait_release", pa, 1);

    // Reset pulse while parked in EXT_WAIT.
    bus_b.io_write_n = 1'b0;
    bus_b.io_channel_ready = 1'b0;
    for (int i = 0; i < 5; i++) cpu_period(pa, pb);
    check("ext_before_reset", pb, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("reset_mid_pr", bus_b.processor_ready, 1);
    check("reset_mid_dma", bus_b.dma_ready, 1);
    bus_b.io_write_n = 1'b1;
    cpu_period(pa, pb);
    check("reset_mid_idle", pb, 1);
    bus_b.io_channel_ready = 1'b1;
    cpu_period(pa, pb);

    // Memory cycle: wait states only when the memory option is built in.
    bus_a.memory_read_n = 1'b0;
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      cpu_period(pa, pb);
      if (pa !== 1'b1) lows++;
    end
    check("mem_wait_periods", 8'(lows), 8'(MEM_LOWS));
    bus_a.memory_read_n = 1'b1;
    cpu_period(pa, pb);
    check("mem_release", pa, 1);

    // Overlapping I/O and memory commands use the I/O count.
    bus_a.io_read_n = 1'b0;
    bus_a.memory_read_n = 1'b0;
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      cpu_period(pa, pb);
      if (pa !== 1'b1) lows++;
    end
    check("io_priority_periods", 8'(lows), 8'd1);
    bus_a.io_read_n = 1'b1;
    bus_a.memory_read_n = 1'b1;
    cpu_period(pa, pb);
    check("io_priority_release", pa, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_ready_controller.md
BUS_READY_CONTROLLER -- requirements
Module: bus_ready_controller

Interface
REQ-001 SHALL have one clock domain; reset is synchronous and active-high.
REQ-002 SHALL expose parameter IO_WAIT_STATES, default 1, meaning the number of cpu_clock wait states inserted in every CPU I/O cycle (range 0-7).
REQ-003 SHALL expose parameter MEM_WAIT_STATES, default 0, meaning the number of cpu_clock wait states inserted in CPU memory cycles (range 0-7; used only under MEM_WAIT_EN).
REQ-004 Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- cpu_clock  in  1  CPU clock level, sampled on clock
- address_enable_n  in  1  0 = CPU owns bus, 1 = DMA owns bus
- io_read_n  in  1  active-low I/O read command
- io_write_n  in  1  active-low I/O write command
- memory_read_n  in  1  active-low memory read command
- memory_write_n  in  1  active-low memory write command
- dma_wait_n  in  1  active-low DMA wait request from the arbiter
- io_channel_ready  in  1  asynchronous expansion-slot ready; 0 = extend cycle
- processor_ready  out  1  ready to CPU
- dma_ready  out  1  ready to DMA controller

Function
REQ-005 SHALL detect cpu_clock edges with a registered prior sample: posedge = ~prev & cur; negedge = prev & ~cur.
REQ-006 SHALL synchronise io_channel_ready through two clock flip-flops (ready_sync); both reset to 1.
REQ-007 SHALL implement the states IDLE, WAIT, EXT_WAIT, DONE; state changes occur only on cpu_clock posedge, except reset.
REQ-008 IDLE -> WAIT at posedge when address_enable_n=0, a qualifying command is low, and the loaded wait count is nonzero; the loaded count is IO_WAIT_STATES for I/O commands, or MEM_WAIT_STATES for memory commands.
REQ-009 IDLE with a qualifying command and a loaded count of 0 SHALL go to DONE if ready_sync=1, else to EXT_WAIT.
REQ-010 If I/O and memory commands are both low, the I/O count SHALL be used.
REQ-011 WAIT SHALL decrement the 3-bit counter at each posedge; at counter=1 it goes to DONE if ready_sync=1, else to EXT_WAIT.
REQ-012 EXT_WAIT SHALL stay while ready_sync=0 and go to DONE on the first posedge with ready_sync=1; it has no timeout.
REQ-013 DONE SHALL return to IDLE at the first posedge where all four commands are high.
REQ-014 In any state, address_enable_n=1 at posedge SHALL force IDLE, aborting a CPU cycle on DMA takeover.
REQ-015 processor_ready SHALL be registered and updated only on cpu_clock negedge to the value (state not WAIT/EXT_WAIT) AND dma_wait_n.
REQ-016 dma_ready SHALL be registered every clock: equal to ready_sync when address_enable_n=1, else 1.
REQ-017 Wait-state latency: with IO_WAIT_STATES=N and ready_sync=1, processor_ready SHALL be low for exactly N cpu_clock periods, measured negedge to negedge.

Reset
REQ-018 On reset: state=IDLE, counter=0, prev cpu_clock=0, ready_sync stages=1, processor_ready=1, dma_ready=1.
REQ-019 Reset asserted mid-WAIT or mid-EXT_WAIT SHALL take effect at the next clock edge regardless of cpu_clock, with outputs at their reset values.

Configuration
REQ-020 Macro BUS_READY_MEM_WAIT_EN defined: memory commands qualify in REQ-008 and load MEM_WAIT_STATES.
REQ-021 Macro BUS_READY_MEM_WAIT_EN undefined: memory commands never qualify, MEM_WAIT_STATES is ignored, and memory cycles never drop processor_ready except through dma_wait_n.

Verification
REQ-022 IO_WAIT_STATES=1, io_read_n low for 4 cpu_clocks, ready high -> processor_ready low for exactly 1 cpu_clock period, then high; state returns to IDLE after io_read_n rises.
REQ-023 IO_WAIT_STATES=3, io_write_n low, io_channel_ready held low for 5 cpu_clocks then high -> processor_ready low for 3 + 5 periods (±1 for synchroniser), then high.
REQ-024 address_enable_n=1, io_channel_ready toggled 1->0->1 -> dma_ready follows with 2-clock latency; processor_ready unaffected unless dma_wait_n=0.
REQ-025 dma_wait_n=0 for 2 cpu_clocks while IDLE -> processor_ready low from the next negedge for 2 periods.
REQ-026 Reset pulsed for 1 clock during EXT_WAIT -> next clock shows processor_ready=1, dma_ready=1, state IDLE.
REQ-027 BUS_READY_MEM_WAIT_EN defined, MEM_WAIT_STATES=2, memory_read_n low -> 2 wait periods; rebuilt without the macro -> 0 wait periods.
